// File: rtl/stopwatch_timer_n.sv
// NUM_DIGITS-digit BCD stopwatch / countdown timer with lap freeze, preset load and expiry flag.
// State is registered; seg is a combinational decode of that state (1 cycle behind the tick); no backpressure, inputs are single-cycle pulses.
module stopwatch_timer_n #(
    parameter int NUM_DIGITS     = 4,
    parameter int TICK_DIV       = 100,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      start_pb,
    input  logic                      lap_pb,
    input  logic                      mode_pb,
    input  logic                      load_en,
    input  logic [4*NUM_DIGITS-1:0]   load_bcd,
    output logic [7*NUM_DIGITS-1:0]   seg,
    output logic                      running,
    output logic                      lap_active,
    output logic                      down_mode,
    output logic                      expired
);
    localparam int CW = 4 * NUM_DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   preset_q, preset_d;
    logic [CW-1:0]   lap_q, lap_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            down_q, down_d;
    logic            lap_act_q, lap_act_d;

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] bcd_clamp(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    logic            tick;
    logic [CW-1:0]   cnt_inc, cnt_dec, cnt_tick, load_clamped;

    assign tick         = (presc_q == PRE_LAST);
    assign cnt_inc      = bcd_inc(count_q);
    assign cnt_dec      = bcd_dec(count_q);
    assign load_clamped = bcd_clamp(load_bcd);
    assign cnt_tick     = !tick ? count_q : (down_q ? cnt_dec : cnt_inc);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            preset_q  <= '0;
            lap_q     <= '0;
            presc_q   <= '0;
            down_q    <= 1'b0;
            lap_act_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            preset_q  <= preset_d;
            lap_q     <= lap_d;
            presc_q   <= presc_d;
            down_q    <= down_d;
            lap_act_q <= lap_act_d;
        end
    end

    // One event per cycle: the highest-priority pulse present is the only one acted on.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        preset_d  = preset_q;
        lap_d     = lap_q;
        presc_d   = presc_q;
        down_d    = down_q;
        lap_act_d = lap_act_q;
        case (state_q)
            IDLE: begin
                if (start_pb) begin
                    if (!(down_q && count_q == '0)) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end else if (lap_pb) begin
                    state_d = IDLE;
                end else if (mode_pb) begin
                    down_d  = !down_q;
                    count_d = down_q ? '0 : preset_q;
                end else if (load_en) begin
                    preset_d = load_clamped;
                    if (down_q) count_d = load_clamped;
                end
            end
            RUN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                count_d = cnt_tick;
                if (start_pb) begin
                    state_d = PAUSE;
                end else if (lap_pb) begin
                    if (!lap_act_q) begin
                        lap_d     = cnt_tick;
                        lap_act_d = 1'b1;
                    end else begin
                        lap_act_d = 1'b0;
                    end
                end
                // Reaching zero while counting down overrides a coincident pause or lap.
                if (tick && down_q && cnt_dec == '0) begin
                    state_d   = EXPIRED;
                    count_d   = '0;
                    lap_act_d = 1'b0;
                end
            end
            PAUSE: begin
                if (start_pb) begin
                    state_d = RUN;
                end else if (lap_pb) begin
                    state_d   = IDLE;
                    count_d   = down_q ? preset_q : '0;
                    lap_act_d = 1'b0;
                end
            end
            EXPIRED: begin
                count_d   = '0;
                lap_act_d = 1'b0;
                if (start_pb || lap_pb) begin
                    state_d = IDLE;
                    count_d = preset_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [CW-1:0]            disp;
    logic [7*NUM_DIGITS-1:0]  seg_raw;

    assign disp = lap_act_q ? lap_q : count_q;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        assign seg_raw[7*g +: 7] = seg7(disp[4*g +: 4]);
    end

    assign seg        = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    assign running    = (state_q == RUN);
    assign expired    = (state_q == EXPIRED);
    assign lap_active = lap_act_q;
    assign down_mode  = down_q;
endmodule

// File: tb/tb_stopwatch_timer_n.sv
// Directed bench for stopwatch_timer_n (4 digits, 4-cycle tick); expectations are queued and checked by a negedge monitor.
module tb_stopwatch_timer_n;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start_pb = 1'b0, lap_pb = 1'b0, mode_pb = 1'b0, load_en = 1'b0;
    logic [15:0] load_bcd = '0;
    logic [27:0] seg;
    logic        running, lap_active, down_mode, expired;

    int checks = 0;
    int errors = 0;

    string       q_name[$];
    logic [27:0] q_seg[$];
    logic [3:0]  q_flg[$];

    stopwatch_timer_n #(.NUM_DIGITS(4), .TICK_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .nrst(nrst), .start_pb(start_pb), .lap_pb(lap_pb), .mode_pb(mode_pb),
        .load_en(load_en), .load_bcd(load_bcd), .seg(seg), .running(running),
        .lap_active(lap_active), .down_mode(down_mode), .expired(expired)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input logic [3:0] d);
        logic [6:0] t [10];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return t[d];
    endfunction

    function automatic logic [27:0] seg_of(input logic [15:0] bcd);
        return {pat(bcd[15:12]), pat(bcd[11:8]), pat(bcd[7:4]), pat(bcd[3:0])};
    endfunction

    task automatic expect_state(input string name, input logic [15:0] bcd,
                                input logic r, input logic l, input logic d, input logic e);
        q_name.push_back(name);
        q_seg.push_back(seg_of(bcd));
        q_flg.push_back({r, l, d, e});
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start; start_pb = 1'b1; cycles(1); start_pb = 1'b0; endtask
    task automatic pulse_lap;   lap_pb   = 1'b1; cycles(1); lap_pb   = 1'b0; endtask
    task automatic pulse_mode;  mode_pb  = 1'b1; cycles(1); mode_pb  = 1'b0; endtask
    task automatic pulse_load;  load_en  = 1'b1; cycles(1); load_en  = 1'b0; endtask

    // Monitor: pops one expectation per negedge and compares display and flags.
    string       m_name;
    logic [27:0] m_seg;
    logic [3:0]  m_flg;
    always @(negedge clk) begin
        if (q_seg.size() > 0) begin
            m_name = q_name.pop_front();
            m_seg  = q_seg.pop_front();
            m_flg  = q_flg.pop_front();
            checks++;
            if (seg !== m_seg) begin
                errors++;
                $display("FAIL %s seg got %h want %h", m_name, seg, m_seg);
            end
            checks++;
            if ({running, lap_active, down_mode, expired} !== m_flg) begin
                errors++;
                $display("FAIL %s flags(run,lap,down,exp) got %b want %b", m_name,
                         {running, lap_active, down_mode, expired}, m_flg);
            end
        end
    end

    initial begin
        cycles(2);
        expect_state("reset", 16'h0000, 0, 0, 0, 0);
        cycles(1);
        nrst = 1'b1;
        cycles(1);

        pulse_start;
        cycles(40);
        expect_state("run40", 16'h0010, 1, 0, 0, 0);
        pulse_start;
        expect_state("pause", 16'h0010, 0, 0, 0, 0);
        cycles(20);
        expect_state("pause_hold", 16'h0010, 0, 0, 0, 0);
        pulse_lap;
        expect_state("pause_clear", 16'h0000, 0, 0, 0, 0);

        start_pb = 1'b1; lap_pb = 1'b1;
        cycles(1);
        start_pb = 1'b0; lap_pb = 1'b0;
        expect_state("start_lap_same", 16'h0000, 1, 0, 0, 0);
        cycles(48);
        expect_state("run12", 16'h0012, 1, 0, 0, 0);
        pulse_lap;
        expect_state("lap_on", 16'h0012, 1, 1, 0, 0);
        cycles(8);
        expect_state("lap_frozen", 16'h0012, 1, 1, 0, 0);
        pulse_lap;
        expect_state("lap_off", 16'h0014, 1, 0, 0, 0);

        pulse_start;
        pulse_lap;
        expect_state("clear2", 16'h0000, 0, 0, 0, 0);
        pulse_start;
        cycles(4 * 9999);
        expect_state("up9999", 16'h9999, 1, 0, 0, 0);
        cycles(4);
        expect_state("up_wrap", 16'h0000, 1, 0, 0, 0);

        cycles(2);
        nrst = 1'b0;
        expect_state("reset_midrun", 16'h0000, 0, 0, 0, 0);
        cycles(2);
        nrst = 1'b1;
        cycles(1);

        pulse_mode;
        expect_state("mode_down", 16'h0000, 0, 0, 1, 0);
        pulse_start;
        expect_state("down_zero_start", 16'h0000, 0, 0, 1, 0);
        cycles(8);
        expect_state("down_zero_idle", 16'h0000, 0, 0, 1, 0);

        load_bcd = 16'h0A03;
        pulse_load;
        expect_state("load_clamp", 16'h0903, 0, 0, 1, 0);
        pulse_start;
        cycles(4 * 903 - 1);
        expect_state("down_0001", 16'h0001, 1, 0, 1, 0);
        cycles(1);
        expect_state("expired", 16'h0000, 0, 0, 1, 1);
        pulse_start;
        expect_state("exp_to_idle", 16'h0903, 0, 0, 1, 0);

        pulse_mode;
        expect_state("mode_up", 16'h0000, 0, 0, 0, 0);
        load_bcd = 16'h1234;
        pulse_load;
        expect_state("load_in_up", 16'h0000, 0, 0, 0, 0);
        pulse_mode;
        expect_state("mode_down_preset", 16'h1234, 0, 0, 1, 0);
        pulse_start;
        pulse_mode;
        expect_state("mode_in_run", 16'h1234, 1, 0, 1, 0);

        cycles(3);
        if (q_seg.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", q_seg.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
